sequential_multiplier: RTL and testbench
========================================

Name: sequential_multiplier

Overview:
- Iterative signed (two's-complement) N×N multiplier producing a 2N-bit product.
- Uses radix-2 Booth recoding: one partial-product step per clock.
- Start/Ready handshake.
- Serves as the MAC element of the MFCC×weight dense-layer datapath, where area matters more than throughput.

Parameters:
- N, 8, operand width in bits; Product is 2N bits. Legal N ≥ 2.

Ports:
- Clock  input  1  rising-edge system clock
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- Multiplicand  input  N  signed operand A; sampled on the accepting Start edge
- Multiplier  input  N  signed operand B; sampled on the accepting Start edge
- Product  output  2N  signed result; registered; held until next completion
- Ready  output  1  high = idle/result valid, able to accept Start
- Start  input  1  request; accepted on a rising Clock edge while Ready=1

Behaviour:
- One clock domain; Reset is asynchronous, active-low.
- Reset (Reset=0, any time, including mid-operation):
  - Ready=1, Product=0.
  - State←IDLE; internal accumulator, operand registers and counter cleared.
  - Any in-flight operation is abandoned.
- States:
  - IDLE (Ready=1): on a rising edge with Start=1:
    - latch Multiplicand into M (sign-extended);
    - A←0, Q←Multiplier, Q₋₁←0, count←N;
    - go to BUSY; Ready=0 from this edge.
  - BUSY (Ready=0): each rising edge does one Booth step:
    - {Q0,Q₋₁}=10: A←A−M
    - {Q0,Q₋₁}=01: A←A+M
    - otherwise: A unchanged
    - then arithmetic-shift {A,Q,Q₋₁} right by 1; count←count−1.
    - When the step with count=1 completes:
      - Product←{A,Q} from that step (the 2N-bit signed product);
      - Ready←1; state←IDLE.
- Latency:
  - Ready falls on the edge that accepts Start.
  - Ready rises exactly N edges later (N+1 cycles Start-to-Ready edge, inclusive).
  - Product is valid when Ready rises.
  - The bench requires Ready=0 one cycle after Start and Ready=1 within 2N+4 cycles.
- Start handling:
  - Start while BUSY is ignored; operands are not re-sampled.
  - Start held high continuously:
    - a new operation is accepted on the first edge after Ready returns to 1;
    - Ready is then high for exactly one cycle.
- Product stability:
  - Product holds its last completed value during BUSY; it does not show partial sums.
  - Product changes only at completion or reset.
- Arithmetic:
  - Exact two's-complement result for all operand pairs, including −2^(N−1)×−2^(N−1) = +2^(2N−2).
  - Accumulator A is N+1 bits internally so that A−M cannot overflow.
- Operand inputs may change freely while BUSY without effect.

Optional Feature:
- Macro: RELU_EN.
- When defined:
  - a ReLU stage is applied at the completion edge: if the signed 2N-bit result is negative, Product←0; otherwise Product←result;
  - Ready timing is unchanged.
- When undefined:
  - Product is the raw signed product;
  - no extra logic is present.

Test Plan:
- Reset then idle (Reset low, release) → Product=16'h0000, Ready=1, with no Start applied.
- Basic product (N=8): Multiplicand=3, Multiplier=5, Start for one cycle →
  - Ready=0 on the next cycle;
  - Ready=1 after 8 edges;
  - Product=16'h000F.
- Signed corners (N=8):
  - −128×−128 → 16'h4000
  - −128×127 → 16'hC080
  - 0×−77 → 16'h0000
  - −1×1 → 16'hFFFF, or 16'h0000 with RELU_EN.
- Busy protection: Start=3×5; change the operands to 7×7 and pulse Start mid-operation → Product=16'h000F, and latency is unchanged.
- Reset mid-operation: Start 100×100, assert Reset after 4 cycles →
  - Ready=1, Product=0 immediately (asynchronously);
  - after release, 2×2 gives 16'h0004.
- Back-to-back sweep: Start held high across 26 consecutive random signed pairs →
  - each Product matches the reference product (ReLU applied when RELU_EN is defined);
  - no timeout occurs.

Source files
------------

// File: rtl/sequential_multiplier.sv
// ---------------------------------------------------------------------------
// sequential_multiplier
//
// Iterative signed (two's-complement) N x N multiplier built around radix-2
// Booth recoding. One partial-product step is retired per clock, so a full
// product takes N clocks after the operands are accepted. This is the MAC
// element of the MFCC x weight dense-layer datapath, where area is worth more
// than throughput.
//
// Optional build macro:
//   RELU_EN  - when defined, a ReLU is folded into the completion edge so a
//              negative result is written to product as zero. Ready timing is
//              identical with or without it.
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset (returns block to idle)
//   start         request; accepted on a rising clk edge while ready=1
//   multiplicand  signed operand A, sampled on the accepting start edge
//   multiplier    signed operand B, sampled on the accepting start edge
//   product       registered 2N-bit signed result, held until next completion
//   ready         high when idle / result valid and start can be accepted
// ---------------------------------------------------------------------------
module sequential_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           ready
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateType;

  stateType state;
  stateType nextState;

  // accReg is one bit wider than the operands so that A - M can never wrap,
  // including the -2^(N-1) x -2^(N-1) corner.
  logic [N:0]       accReg;
  logic [N:0]       mReg;
  logic [N-1:0]     qReg;
  logic             qMinus;
  logic [CNT_W-1:0] count;

  logic             accept;
  logic             lastStep;
  logic [N:0]       sum;
  logic [N:0]       shiftedAcc;
  logic [N-1:0]     shiftedQ;
  logic [2*N-1:0]   result;

  assign lastStep = (count == CNT_W'(1));

  // State register: the only place the FSM state is stored. Reset drops any
  // in-flight operation straight back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: idle waits for a start request, busy runs until the
  // step taken with count=1 has been retired. A start seen while busy has no
  // effect on the sequence.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start)    nextState = BUSY;
      BUSY:    if (lastStep) nextState = IDLE;
      default:               nextState = IDLE;
    endcase
  end

  // Output logic: ready is a pure decode of the state, so it falls on the
  // accepting edge and reacts to the asynchronous reset immediately.
  always_comb begin
    ready  = (state == IDLE);
    accept = (state == IDLE) && start;
  end

  // One Booth step: the pair {Q0, Q-1} selects subtract, add or hold, and the
  // combined {A, Q, Q-1} register is then shifted right arithmetically. The
  // low 2N bits of the shifted {A, Q} form the product after the last step;
  // the extra top bit of A is only a guard bit and is dropped there.
  always_comb begin
    sum = accReg;
    case ({qReg[0], qMinus})
      2'b10:   sum = accReg - mReg;
      2'b01:   sum = accReg + mReg;
      default: sum = accReg;
    endcase
    shiftedAcc = {sum[N], sum[N:1]};
    shiftedQ   = {sum[0], qReg[N-1:1]};
    result     = {shiftedAcc[N-1:0], shiftedQ};
  end

  // Datapath registers: loaded with fresh operands on the accepting edge,
  // then advanced by one Booth step on every busy edge. Operand inputs are
  // ignored at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accReg <= '0;
      mReg   <= '0;
      qReg   <= '0;
      qMinus <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      accReg <= '0;
      mReg   <= {multiplicand[N-1], multiplicand};
      qReg   <= multiplier;
      qMinus <= 1'b0;
      count  <= CNT_W'(N);
    end else if (state == BUSY) begin
      accReg <= shiftedAcc;
      qReg   <= shiftedQ;
      qMinus <= qReg[0];
      count  <= count - CNT_W'(1);
    end
  end

  // Result register: written only on the completion edge, so partial sums
  // are never visible and the previous product is held while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if ((state == BUSY) && lastStep) begin
`ifdef RELU_EN
      product <= result[2*N-1] ? '0 : result;
`else
      product <= result;
`endif
    end
  end

endmodule

// File: tb/tb_sequential_multiplier.sv
// ---------------------------------------------------------------------------
// tb_sequential_multiplier
//
// Self-checking bench for sequential_multiplier (N=8). Expected products are
// pushed to a queue when an operation is started and popped when ready
// returns high. Build with +define+RELU_EN to exercise the ReLU variant; the
// reference model follows the same macro.
// ---------------------------------------------------------------------------
module tb_sequential_multiplier;

  localparam int N = 8;

`ifdef RELU_EN
  localparam logic [2*N-1:0] NEG_ONE_EXP = 16'h0000;
`else
  localparam logic [2*N-1:0] NEG_ONE_EXP = 16'hFFFF;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           ready;

  int testCount;
  int failCount;
  logic [2*N-1:0] expQ[$];

  sequential_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench itself gets stuck somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product from the operand values, with ReLU when enabled.
  function automatic logic [2*N-1:0] refProduct(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] p;
    p = $signed(a) * $signed(b);
`ifdef RELU_EN
    if (p < 0) p = '0;
`endif
    return p;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Present operands with start for one cycle, optionally record the expected
  // result, and confirm ready has dropped after the accepting edge. Returns at
  // the falling edge right after the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input bit doPush);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    if (doPush) expQ.push_back(refProduct(a, b));
    @(negedge clk);
    start = 1'b0;
    checkOutput("readyLow", 32'(ready), 32'd0);
  endtask

  // Wait (bounded) for ready, then check latency in edges after the accepting
  // edge and the product against the scoreboard. Returns at the falling edge
  // where ready is first seen high.
  task automatic waitAndCheck(input string tag, input int elapsed);
    int n;
    logic [2*N-1:0] want;
    n = elapsed;
    while (!ready && n < 2*N + 4) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "Timeout"}, 32'(ready), 32'd1);
    checkOutput({tag, "Latency"}, 32'(n), 32'(N));
    if (expQ.size() == 0) begin
      checkOutput({tag, "QueueEmpty"}, 32'd0, 32'd1);
    end else begin
      want = expQ.pop_front();
      checkOutput({tag, "Product"}, 32'(product), 32'(want));
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    testCount    = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    checkOutput("resetReady", 32'(ready), 32'd1);
    checkOutput("resetProduct", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idleReady", 32'(ready), 32'd1);
    checkOutput("idleProduct", 32'(product), 32'd0);

    // Basic product
    applyStimulus(8'd3, 8'd5, 1'b1);
    waitAndCheck("basic", 0);
    checkOutput("basicConst", 32'(product), 32'h000F);

    // Signed corners
    applyStimulus(8'h80, 8'h80, 1'b1);
    waitAndCheck("minMin", 0);
    checkOutput("minMinConst", 32'(product), 32'h4000);
    applyStimulus(8'h80, 8'h7F, 1'b1);
    waitAndCheck("minMax", 0);
`ifdef RELU_EN
    checkOutput("minMaxConst", 32'(product), 32'h0000);
`else
    checkOutput("minMaxConst", 32'(product), 32'hC080);
`endif
    applyStimulus(8'd0, 8'hB3, 1'b1);
    waitAndCheck("zero", 0);
    checkOutput("zeroConst", 32'(product), 32'h0000);
    applyStimulus(8'hFF, 8'h01, 1'b1);
    waitAndCheck("negOne", 0);
    checkOutput("negOneConst", 32'(product), 32'(NEG_ONE_EXP));

    // Busy protection: new operands and a start pulse mid-operation
    applyStimulus(8'd3, 8'd5, 1'b1);
    @(negedge clk);
    multiplicand = 8'd7;
    multiplier   = 8'd7;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyStillLow", 32'(ready), 32'd0);
    waitAndCheck("busy", 2);
    checkOutput("busyConst", 32'(product), 32'h000F);

    // Reset mid-operation
    applyStimulus(8'd100, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetReady", 32'(ready), 32'd1);
    checkOutput("midResetProduct", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd2, 8'd2, 1'b1);
    waitAndCheck("afterReset", 0);
    checkOutput("afterResetConst", 32'(product), 32'h0004);

    // Back-to-back sweep with start held high
    @(negedge clk);
    ra = N'($urandom_range(0, 255));
    rb = N'($urandom_range(0, 255));
    multiplicand = ra;
    multiplier   = rb;
    start        = 1'b1;
    expQ.push_back(refProduct(ra, rb));
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      checkOutput("b2bReadyLow", 32'(ready), 32'd0);
      waitAndCheck("b2b", 0);
      if (i < 25) begin
        ra = N'($urandom_range(0, 255));
        rb = N'($urandom_range(0, 255));
        multiplicand = ra;
        multiplier   = rb;
        expQ.push_back(refProduct(ra, rb));
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    checkOutput("finalIdle", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
